// File: rtl/fir_cfg_ctrl.sv
// AXI-Lite configuration/sequencing controller for the FIR engine: ap_ctrl, data_length, tap-RAM arbitration.
// Optional build macro FIR_CFG_CYCLE_CNT_EN adds a read-only run-cycle counter at 0x14.
module fir_cfg_ctrl #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   input  logic                   eng_tap_en,
   input  logic [3:0]             eng_tap_idx,
   output logic                   ap_start,
   input  logic                   eng_first,
   input  logic                   eng_last,
   output logic [31:0]            data_length
);

   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
   localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32'h20 + 4 * (Tape_Num - 1));
`ifdef FIR_CFG_CYCLE_CNT_EN
   localparam logic [pADDR_WIDTH-1:0] ADDR_CNT  = pADDR_WIDTH'(32'h14);
`endif

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {C_IDLE, C_START, C_RUN} ctl_state_t;

   function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
      return (a >= TAP_BASE) && (a <= TAP_LAST) && (a[1:0] == 2'b00);
   endfunction

   rd_state_t                rd_state, rd_next;
   ctl_state_t               ctl_state, ctl_next;
   logic                     wr_ack;
   logic                     wr_start;
   logic [pADDR_WIDTH-1:0]   wa_q;
   logic [pDATA_WIDTH-1:0]   wd_q;
   logic [pADDR_WIDTH-1:0]   ra_q;
   logic                     rd_start;
   logic                     rd_tap_ok;
   logic                     rvalid_q;
   logic [pDATA_WIDTH-1:0]   rdata_q;
   logic [pDATA_WIDTH-1:0]   rd_mux;
   logic                     rd_done;
   logic                     ap_idle;
   logic                     ap_done;
   logic                     start_acc;

   // ---------------- write channel ----------------
   assign wr_start = awvalid & wvalid & ~wr_ack;
   assign awready  = wr_ack;
   assign wready   = wr_ack;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         wr_ack <= 1'b0;
         wa_q   <= '0;
         wd_q   <= '0;
      end else begin
         wr_ack <= wr_start;
         if (wr_start) begin
            wa_q <= awaddr;
            wd_q <= wdata;
         end
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n)
         data_length <= '0;
      else if (wr_ack && (wa_q == ADDR_LEN) && ap_idle)
         data_length <= 32'(wd_q);
   end

   // ---------------- read FSM ----------------
   // A pending write handshake blocks read start, so host tap read and write never share a cycle.
   assign rd_start = (rd_state == R_IDLE) & arvalid & ~(awvalid & wvalid);

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) rd_state <= R_IDLE;
      else             rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      arready = 1'b0;
      case (rd_state)
         R_IDLE: if (rd_start) rd_next = R_ADDR;
         R_ADDR: begin
            arready = 1'b1;
            rd_next = R_DATA;
         end
         R_DATA: if (rvalid_q && rready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

`ifdef FIR_CFG_CYCLE_CNT_EN
   logic [31:0] cyc_cnt;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n)
         cyc_cnt <= '0;
      else if (start_acc)
         cyc_cnt <= '0;
      else if (!ap_idle && (cyc_cnt != '1))
         cyc_cnt <= cyc_cnt + 32'd1;
   end
`endif

   always_comb begin
      rd_mux = '0;
      if (ra_q == ADDR_CTRL)
         rd_mux = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
      else if (ra_q == ADDR_LEN)
         rd_mux = pDATA_WIDTH'(data_length);
`ifdef FIR_CFG_CYCLE_CNT_EN
      else if (ra_q == ADDR_CNT)
         rd_mux = pDATA_WIDTH'(cyc_cnt);
`endif
      else if (is_tap(ra_q))
         rd_mux = rd_tap_ok ? tap_Do : '1;
   end

   // First R_DATA cycle captures the registered RAM output; rvalid rises one cycle later.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         ra_q      <= '0;
         rd_tap_ok <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (rd_start) ra_q <= araddr;
         if (rd_state == R_ADDR) rd_tap_ok <= ap_idle;
         if (rd_state == R_DATA) begin
            if (!rvalid_q) begin
               rvalid_q <= 1'b1;
               rdata_q  <= rd_mux;
            end else if (rready) begin
               rvalid_q <= 1'b0;
            end
         end
      end
   end

   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rd_done = rvalid_q & rready & (ra_q == ADDR_CTRL);

   // ---------------- control FSM ----------------
   assign start_acc = wr_ack & (wa_q == ADDR_CTRL) & wd_q[0] & (ctl_state == C_IDLE);

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) ctl_state <= C_IDLE;
      else             ctl_state <= ctl_next;
   end

   always_comb begin
      ctl_next = ctl_state;
      ap_start = 1'b0;
      ap_idle  = 1'b0;
      case (ctl_state)
         C_IDLE: begin
            ap_idle = 1'b1;
            if (start_acc) ctl_next = C_START;
         end
         C_START: begin
            ap_start = 1'b1;
            if (eng_first) ctl_next = C_RUN;
         end
         C_RUN: if (eng_last) ctl_next = C_IDLE;
         default: ctl_next = C_IDLE;
      endcase
   end

   // Completion set takes priority over the clear-on-read of 0x00.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n)
         ap_done <= 1'b0;
      else if (start_acc)
         ap_done <= 1'b0;
      else if ((ctl_state == C_RUN) && eng_last)
         ap_done <= 1'b1;
      else if (rd_done)
         ap_done <= 1'b0;
   end

   // ---------------- tap RAM arbitration ----------------
   always_comb begin
      tap_WE = 4'h0;
      tap_EN = 1'b0;
      tap_Di = '0;
      tap_A  = '0;
      if (!ap_idle) begin
         tap_EN = eng_tap_en;
         tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
      end else if (wr_ack && is_tap(wa_q)) begin
         tap_EN = 1'b1;
         tap_WE = 4'hF;
         tap_A  = wa_q - TAP_BASE;
         tap_Di = wd_q;
      end else if ((rd_state == R_ADDR) && is_tap(ra_q)) begin
         tap_EN = 1'b1;
         tap_A  = ra_q - TAP_BASE;
      end
   end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed self-checking bench for fir_cfg_ctrl with a behavioural 1-cycle tap RAM.
module tb_fir_cfg_ctrl;

   logic        axis_clk;
   logic        axis_rst_n;
   logic        awvalid, awready, wvalid, wready;
   logic [11:0] awaddr;
   logic [31:0] wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [11:0] araddr;
   logic [31:0] rdata;
   logic [3:0]  tap_WE;
   logic        tap_EN;
   logic [31:0] tap_Di;
   logic [11:0] tap_A;
   logic [31:0] tap_Do;
   logic        eng_tap_en;
   logic [3:0]  eng_tap_idx;
   logic        ap_start;
   logic        eng_first, eng_last;
   logic [31:0] data_length;

   int total = 0;
   int bad   = 0;

   logic [31:0] ram [64];

   fir_cfg_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
      .eng_tap_en(eng_tap_en), .eng_tap_idx(eng_tap_idx),
      .ap_start(ap_start), .eng_first(eng_first), .eng_last(eng_last),
      .data_length(data_length)
   );

   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   always @(posedge axis_clk) begin
      if (tap_EN) begin
         if (tap_WE == 4'hF) ram[tap_A[7:2]] <= tap_Di;
         tap_Do <= ram[tap_A[7:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output int we_cycles);
      int n;
      we_cycles = 0;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin
         @(negedge axis_clk);
         n++;
         if (tap_WE == 4'hF) we_cycles++;
      end while (!awready && n < 20);
      check("awready", {31'b0, awready}, 32'd1);
      @(negedge axis_clk);
      awvalid = 1'b0; wvalid = 1'b0;
      if (tap_WE == 4'hF) we_cycles++;
      @(negedge axis_clk);
      if (tap_WE == 4'hF) we_cycles++;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
      int n;
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin
         @(negedge axis_clk);
         n++;
      end while (!arready && n < 20);
      check("arready", {31'b0, arready}, 32'd1);
      lat = 0;
      do begin
         @(negedge axis_clk);
         arvalid = 1'b0;
         lat++;
      end while (!rvalid && lat < 20);
      d = rdata;
      @(negedge axis_clk);
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      int lat;
      axi_read(a, d, lat);
      check(tag, d, exp);
      check({tag, "_lat"}, 32'(lat), 32'd2);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d, input int exp_we);
      int we;
      axi_write(a, d, we);
      check("tap_we_cycles", 32'(we), 32'(exp_we));
   endtask

   initial begin
      int taps [11];
      int n, lat;
      taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

      axis_rst_n = 1'b0;
      awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
      arvalid = 0; araddr = '0; rready = 1'b1;
      eng_tap_en = 0; eng_tap_idx = '0; eng_first = 0; eng_last = 0;
      repeat (3) @(negedge axis_clk);
      check("rst_awready", {31'b0, awready}, 32'd0);
      check("rst_arready", {31'b0, arready}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ap_start", {31'b0, ap_start}, 32'd0);
      check("rst_data_length", data_length, 32'd0);
      check("rst_tap_en_we", {27'b0, tap_EN, tap_WE}, 32'd0);
      check("rst_tap_a", {20'b0, tap_A}, 32'd0);
      axis_rst_n = 1'b1;
      @(negedge axis_clk);

      rd_chk("ctrl_after_reset", 12'h000, 32'h4);
      wr(12'h010, 32'd600, 0);
      check("data_length_port", data_length, 32'd600);
      rd_chk("data_length_rd", 12'h010, 32'd600);

      for (int i = 0; i < 11; i++) wr(12'h020 + 12'(4 * i), 32'(taps[i]), 1);
      for (int i = 0; i < 11; i++) rd_chk("tap_rd", 12'h020 + 12'(4 * i), 32'(taps[i]));

      rd_chk("unmapped_rd", 12'h080, 32'h0);
      rd_chk("unaligned_tap_rd", 12'h022, 32'h0);
      wr(12'h084, 32'd123, 0);
      rd_chk("unmapped_wr_dropped", 12'h010, 32'd600);

      // first run
      wr(12'h000, 32'h1, 0);
      check("ap_start_set", {31'b0, ap_start}, 32'd1);
      rd_chk("ctrl_starting", 12'h000, 32'h1);
      wr(12'h010, 32'd5, 0);
      rd_chk("len_locked_running", 12'h010, 32'd600);
      eng_first = 1'b1;
      @(negedge axis_clk);
      eng_first = 1'b0;
      check("ap_start_cleared", {31'b0, ap_start}, 32'd0);
      rd_chk("ctrl_running", 12'h000, 32'h0);
      wr(12'h024, 32'h55, 0);
      check("tap_ram_untouched", ram[1], 32'hFFFF_FFF6);
      rd_chk("tap_rd_running", 12'h024, 32'hFFFF_FFFF);
      eng_tap_idx = 4'd5; eng_tap_en = 1'b1;
      #1;
      check("eng_tap_a", {20'b0, tap_A}, 32'h14);
      check("eng_tap_en_we", {27'b0, tap_EN, tap_WE}, 32'h10);
      @(negedge axis_clk);
      eng_tap_en = 1'b0;
      eng_last = 1'b1;
      @(negedge axis_clk);
      eng_last = 1'b0;
      rd_chk("ctrl_done", 12'h000, 32'h6);
      rd_chk("ctrl_done_cleared", 12'h000, 32'h4);

      // second run; eng_last lands on the cycle the 0x00 read completes
      wr(12'h000, 32'h1, 0);
      check("ap_start_run2", {31'b0, ap_start}, 32'd1);
      eng_first = 1'b1;
      @(negedge axis_clk);
      eng_first = 1'b0;
      rready = 1'b0; araddr = 12'h000; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(negedge axis_clk); n++; end
      check("collide_arready", {31'b0, arready}, 32'd1);
      lat = 0;
      do begin @(negedge axis_clk); arvalid = 1'b0; lat++; end while (!rvalid && lat < 20);
      check("collide_rdata", rdata, 32'h0);
      rready = 1'b1; eng_last = 1'b1;
      @(negedge axis_clk);
      eng_last = 1'b0;
      check("collide_rvalid_low", {31'b0, rvalid}, 32'd0);
      rd_chk("done_set_wins", 12'h000, 32'h6);
      rd_chk("done_cleared_run2", 12'h000, 32'h4);

      // reset in the middle of a run
      wr(12'h000, 32'h1, 0);
      check("ap_start_run3", {31'b0, ap_start}, 32'd1);
      axis_rst_n = 1'b0;
      #1;
      check("midrst_ap_start", {31'b0, ap_start}, 32'd0);
      check("midrst_len", data_length, 32'd0);
      @(negedge axis_clk);
      axis_rst_n = 1'b1;
      @(negedge axis_clk);
      rd_chk("midrst_ctrl", 12'h000, 32'h4);
      rd_chk("midrst_tap_kept", 12'h028, 32'hFFFF_FFF7);

      // simultaneous write and read, then a stalled read response
      rready = 1'b0;
      awaddr = 12'h010; wdata = 32'd700; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 12'h010; arvalid = 1'b1;
      @(negedge axis_clk);
      check("prio_awready", {31'b0, awready}, 32'd1);
      check("prio_read_held", {31'b0, arready}, 32'd0);
      @(negedge axis_clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("prio_read_wait", {31'b0, arready}, 32'd0);
      n = 0;
      while (!arready && n < 20) begin @(negedge axis_clk); n++; end
      check("prio_arready", {31'b0, arready}, 32'd1);
      lat = 0;
      do begin @(negedge axis_clk); arvalid = 1'b0; lat++; end while (!rvalid && lat < 20);
      check("prio_lat", 32'(lat), 32'd2);
      check("prio_rdata", rdata, 32'd700);
      for (int i = 0; i < 5; i++) begin
         @(negedge axis_clk);
         check("hold_rvalid", {31'b0, rvalid}, 32'd1);
         check("hold_rdata", rdata, 32'd700);
      end
      rready = 1'b1;
      @(negedge axis_clk);
      check("hold_release", {31'b0, rvalid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_cfg_ctrl.md
Name: fir_cfg_ctrl

Overview:
- AXI-Lite configuration and sequencing controller for the FIR engine.
- Owns the ap_ctrl/status register and the data_length register.
- Arbitrates the single tap-RAM port between AXI-Lite host access and the engine's coefficient fetch.
- Issues ap_start to the engine and tracks completion (ap_done/ap_idle) from the engine's last-output handshake.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and tap-RAM address width
pDATA_WIDTH, 32, data width
Tape_Num, 11, number of taps; tap register window 0x20..0x20+4*(Tape_Num-1)

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  pADDR_WIDTH  write address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  pDATA_WIDTH  write data
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  pADDR_WIDTH  read address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  pDATA_WIDTH  read data
tap_WE  out  4  tap RAM byte write enable
tap_EN  out  1  tap RAM enable
tap_Di  out  pDATA_WIDTH  tap RAM write data
tap_A  out  pADDR_WIDTH  tap RAM byte address
tap_Do  in  pDATA_WIDTH  tap RAM read data (1-cycle registered)
eng_tap_en  in  1  engine tap read request
eng_tap_idx  in  4  engine tap index
ap_start  out  1  start level to engine
eng_first  in  1  engine accepted first ss sample (ss_tvalid&ss_tready)
eng_last  in  1  engine last output accepted (sm_tvalid&sm_tready&sm_tlast)
data_length  out  32  sample count register

Behaviour:
- Reset values: awready=wready=arready=rvalid=0; rdata=0; tap_WE=0; tap_EN=0; tap_A=0; tap_Di=0; ap_start=0; data_length=0; ap_done=0; ap_idle=1.
- Register map:
  - 0x00: bit0 ap_start, bit1 ap_done, bit2 ap_idle; other bits read 0.
  - 0x10: data_length.
  - 0x20+4k: tap k.
  - Unmapped reads return 0; unmapped writes are dropped.
- Write channel:
  - Accepted only when awvalid&wvalid are both high.
  - awready and wready pulse high together for exactly one cycle; no skid.
  - Write has priority over a read request in the same cycle; the read waits.
- Read FSM:
  - R_IDLE -> R_ADDR when arvalid and no write is being accepted; arready pulses 1 cycle.
  - R_ADDR -> R_DATA next cycle; a tap read drives tap_EN with tap_A and captures tap_Do.
  - R_DATA: rvalid=1, held until rready; then -> R_IDLE.
  - Read latency from arready to rvalid is 2 cycles.
- Tap RAM arbitration:
  - When ap_idle=0, the engine owns the port: tap_A={eng_tap_idx,2'b00}, tap_EN=eng_tap_en, tap_WE=0.
  - Host tap writes while running: acknowledged and dropped.
  - Host tap reads while running: return 0xFFFFFFFF.
  - When idle, the host owns the port; a tap write drives tap_WE=4'hF for 1 cycle.
- Control FSM:
  - IDLE -> START on a write to 0x00 with bit0=1 and ap_idle=1. Sets ap_start=1 and ap_idle=0, and clears ap_done.
  - START: ap_start held until eng_first, then ap_start=0 -> RUN.
  - RUN -> IDLE on eng_last. Sets ap_done=1 and ap_idle=1 in the same cycle.
  - ap_start writes while not idle are ignored.
  - data_length writes while not idle are ignored.
- ap_done clears on the cycle the host read of 0x00 completes (rvalid&rready). If eng_last coincides with that read, set wins.
- Reset mid-operation: all state returns to reset values immediately; tap RAM contents are untouched.

Optional Feature:
- Macro FIR_CFG_CYCLE_CNT_EN.
- Defined: register 0x14 is a read-only 32-bit counter.
  - Cleared on ap_start acceptance.
  - Increments every cycle in START/RUN.
  - Holds its value in IDLE; saturates at 0xFFFFFFFF.
- Undefined: 0x14 reads 0 and no counter logic is built.

Test Plan:
- After reset, read 0x00 -> rdata=0x4. Write 0x10=600, read back -> 600.
- Write taps 0,-10,-9,23,56,63,56,23,-9,-10,0 to 0x20..0x48 while idle, read back -> exact values; tap_WE=4'hF one cycle per write.
- Write 0x00=1 -> ap_start=1 and 0x00 reads ap_idle=0. Pulse eng_first -> ap_start=0.
- Write tap 0x24=0x55 during RUN -> RAM unchanged, and read 0x24 returns 0xFFFFFFFF. Drive eng_tap_idx=5 -> tap_A=0x14.
- Pulse eng_last -> 0x00 reads 0x6; second read of 0x00 returns 0x4. Restart with 0x00=1 works for a second run.
- Assert awvalid/wvalid and arvalid together -> write completes first, read returns rvalid 2 cycles after its arready. Hold rready=0 for 5 cycles -> rvalid and rdata stay stable.
